// File: rtl/pending_pe_pkg.sv
// rtl/pending_pe_pkg.sv - shared constants and helpers for pending_priority_encoder
package pending_pe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 64;

  // One-hot vector with only bit idx set; callers size-cast to their width.
  function automatic logic [MAX_WIDTH-1:0] idx_to_onehot(input int unsigned idx);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pending_priority_encoder_if.sv
// rtl/pending_priority_encoder_if.sv - valid/ready index port of pending_priority_encoder
interface pending_priority_encoder_if #(
  parameter int WIDTH = 8
) ();
  localparam int IDX_W = $clog2(WIDTH);

  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_idx, output out_valid, input out_ready);
  modport slave  (input out_idx, input out_valid, output out_ready);
endinterface

// File: rtl/pe_find_msb.sv
// rtl/pe_find_msb.sv - highest set bit search in descending order starting at rot_i-1
module pe_find_msb #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  input  logic [IDX_W-1:0] rot_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from lowest to highest priority so the last hit is the winner.
  // Priority step k examines bit (rot_i-1-k) mod WIDTH; rot_i=0 gives MSB-first.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      int j;
      j = (int'(rot_i) + WIDTH - 1 - k) % WIDTH;
      if (vec_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/pending_priority_encoder.sv
// rtl/pending_priority_encoder.sv - sticky pending requests, highest priority index out (PPE_ROUND_ROBIN_EN selects rotating priority)
module pending_priority_encoder
  import pending_pe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            req_in,
  pending_priority_encoder_if.master  out_if,
  output logic [WIDTH-1:0]            pending_o,
  output logic                        overflow_o
);

  logic [WIDTH-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [IDX_W-1:0] rot;
  logic [IDX_W-1:0] sel_idx;
  logic             found;
  logic             accept;
  logic [WIDTH-1:0] acc_mask;

`ifdef PPE_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Pointer follows the last accepted index; held when nothing is accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = sel_idx;
  end

  // Rotation pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign rot = ptr_q;
`else
  assign rot = '0;
`endif

  pe_find_msb #(.WIDTH(WIDTH)) u_find (
    .vec_i   (pending_q),
    .rot_i   (rot),
    .found_o (found),
    .idx_o   (sel_idx)
  );

  assign out_if.out_valid = found;
  assign out_if.out_idx   = sel_idx;
  assign pending_o        = pending_q;
  assign overflow_o       = overflow_q;

  // Accepted bit is cleared, new requests set; a same-cycle re-request wins.
  always_comb begin
    accept     = found && out_if.out_ready;
    acc_mask   = '0;
    if (accept) acc_mask = WIDTH'(idx_to_onehot(32'(sel_idx)));
    pending_d  = (pending_q & ~acc_mask) | req_in;
    overflow_d = overflow_q | (|(req_in & pending_q & ~acc_mask));
  end

  // Pending vector and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
